// File: rtl/jam_enum.sv
// Exhaustive job-assignment solver: walks every worker->job permutation in
// lexicographic order, sums ROM costs and keeps the min or max total.
module jam_enum #(
  parameter int N      = 8,
  parameter int COST_W = 7,
  parameter int CNT_W  = 16,
  localparam int IDX_W = (N <= 2) ? 1 : $clog2(N),
  localparam int SUM_W = COST_W + $clog2(N)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Start,
  input  logic                 Mode,
  output logic [IDX_W-1:0]     W,
  output logic [IDX_W-1:0]     J,
  input  logic [COST_W-1:0]    Cost,
  output logic                 Busy,
  output logic                 Valid,
  output logic [SUM_W-1:0]     BestCost,
  output logic [CNT_W-1:0]     MatchCount,
  output logic [N*IDX_W-1:0]   BestPerm,
  output logic [2:0]           fsm_state
);

  // Handshake: Start is sampled only in IDLE; Busy is high from the next cycle
  // until DONE is left; Valid pulses for the single DONE cycle and the result
  // outputs stay stable from then until the next accepted run reloads them.
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_LAST = 3'd2;
  localparam logic [2:0] S_COMP = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       state;
  logic [IDX_W-1:0] perm     [N];
  logic [IDX_W-1:0] nxt_perm [N];
  logic [IDX_W-1:0] swp      [N];
  logic [IDX_W-1:0] rd_cnt;
  logic [IDX_W-1:0] piv;
  logic [IDX_W-1:0] succ;
  logic [IDX_W-1:0] rev;
  logic [SUM_W-1:0] acc;
  logic             mode_q;
  logic             first;
  logic             is_last;
  logic             better;

  // Next permutation: rightmost ascent is the pivot, swap with the rightmost
  // larger element, then mirror the (descending) suffix.
  always_comb begin
    piv  = '0;
    succ = '0;
    rev  = '0;
    for (int i = 0; i < N - 1; i++) begin
      if (perm[i] < perm[i+1]) piv = IDX_W'(i);
    end
    for (int k = 0; k < N; k++) begin
      if (IDX_W'(k) > piv && perm[k] > perm[piv]) succ = IDX_W'(k);
    end
    swp       = perm;
    swp[piv]  = perm[succ];
    swp[succ] = perm[piv];
    nxt_perm  = swp;
    for (int k = 0; k < N; k++) begin
      if (IDX_W'(k) > piv) begin
        rev         = IDX_W'(N - k) + piv;
        nxt_perm[k] = swp[rev];
      end
    end
  end

  always_comb begin
    is_last = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (perm[k] != IDX_W'(N - 1 - k)) is_last = 1'b0;
    end
  end

  assign better = mode_q ? (acc > BestCost) : (acc < BestCost);

  always_comb begin
    W = '0;
    J = '0;
    if (state == S_READ) begin
      W = rd_cnt;
      J = perm[rd_cnt];
    end else if (state == S_LAST) begin
      W = IDX_W'(N - 1);
      J = perm[N-1];
    end
  end

  assign Busy      = (state != S_IDLE);
  assign Valid     = (state == S_DONE);
  assign fsm_state = state;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= S_IDLE;
      rd_cnt     <= '0;
      acc        <= '0;
      mode_q     <= 1'b0;
      first      <= 1'b0;
      for (int k = 0; k < N; k++) perm[k] <= '0;
      BestCost   <= '0;
      MatchCount <= '0;
      BestPerm   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            state  <= S_READ;
            rd_cnt <= '0;
            acc    <= '0;
            mode_q <= Mode;
            first  <= 1'b1;
            for (int k = 0; k < N; k++) perm[k] <= IDX_W'(k);
          end
        end
        S_READ: begin
          // Cost lags the address by one cycle, so cycle 0 has nothing to add.
          if (rd_cnt != '0) acc <= acc + SUM_W'(Cost);
          if (rd_cnt == IDX_W'(N - 1)) state <= S_LAST;
          else rd_cnt <= rd_cnt + IDX_W'(1);
        end
        S_LAST: begin
          acc   <= acc + SUM_W'(Cost);
          state <= S_COMP;
        end
        S_COMP: begin
          first <= 1'b0;
          if (first || better) begin
            BestCost   <= acc;
            MatchCount <= CNT_W'(1);
            for (int k = 0; k < N; k++) BestPerm[k*IDX_W +: IDX_W] <= perm[k];
          end else if (acc == BestCost && MatchCount != '1) begin
            MatchCount <= MatchCount + CNT_W'(1);
          end
          if (is_last) begin
            state <= S_DONE;
          end else begin
            perm   <= nxt_perm;
            acc    <= '0;
            rd_cnt <= '0;
            state  <= S_READ;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jam_enum.sv
// Bench for jam_enum: three instances (N=3, N=4 with a 3-bit counter, N=2)
// share one cost table; results are checked against a brute-force model.
module tb_jam_enum;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] start_v;
  logic [2:0] mode_v;
  int         total = 0;
  int         bad = 0;
  int         sel = 0;
  int         ct [8][8];

  always #5 clk = ~clk;

  logic [1:0] w3, j3;
  logic [6:0] cost3;
  logic       busy3, valid3;
  logic [8:0] best3;
  logic [15:0] cnt3;
  logic [5:0] perm3;
  logic [2:0] st3;

  logic [1:0] w4, j4;
  logic [2:0] cost4;
  logic       busy4, valid4;
  logic [4:0] best4;
  logic [2:0] cnt4;
  logic [7:0] perm4;
  logic [2:0] st4;

  logic       w2, j2;
  logic [3:0] cost2;
  logic       busy2, valid2;
  logic [4:0] best2;
  logic [7:0] cnt2;
  logic [1:0] perm2;
  logic [2:0] st2;

  jam_enum #(.N(3), .COST_W(7), .CNT_W(16)) dut3 (
    .CLK(clk), .RST(rst_n), .Start(start_v[0]), .Mode(mode_v[0]), .W(w3), .J(j3),
    .Cost(cost3), .Busy(busy3), .Valid(valid3), .BestCost(best3), .MatchCount(cnt3),
    .BestPerm(perm3), .fsm_state(st3));

  jam_enum #(.N(4), .COST_W(3), .CNT_W(3)) dut4 (
    .CLK(clk), .RST(rst_n), .Start(start_v[1]), .Mode(mode_v[1]), .W(w4), .J(j4),
    .Cost(cost4), .Busy(busy4), .Valid(valid4), .BestCost(best4), .MatchCount(cnt4),
    .BestPerm(perm4), .fsm_state(st4));

  jam_enum #(.N(2), .COST_W(4), .CNT_W(8)) dut2 (
    .CLK(clk), .RST(rst_n), .Start(start_v[2]), .Mode(mode_v[2]), .W(w2), .J(j2),
    .Cost(cost2), .Busy(busy2), .Valid(valid2), .BestCost(best2), .MatchCount(cnt2),
    .BestPerm(perm2), .fsm_state(st2));

  // Cost ROM with one cycle of read latency.
  always @(posedge clk) begin
    cost3 <= 7'(ct[w3][j3]);
    cost4 <= 3'(ct[w4][j4]);
    cost2 <= 4'(ct[w2][j2]);
  end

  logic [31:0] obs_w, obs_j, obs_best, obs_cnt, obs_perm;
  logic        obs_busy, obs_valid;

  // Selected instance, with BestPerm re-packed into 4-bit fields.
  always_comb begin
    obs_w = '0; obs_j = '0; obs_best = '0; obs_cnt = '0; obs_perm = '0;
    obs_busy = 1'b0; obs_valid = 1'b0;
    case (sel)
      0: begin
        obs_w = 32'(w3); obs_j = 32'(j3); obs_best = 32'(best3); obs_cnt = 32'(cnt3);
        obs_busy = busy3; obs_valid = valid3;
        for (int k = 0; k < 3; k++) obs_perm[4*k +: 4] = 4'(perm3[2*k +: 2]);
      end
      1: begin
        obs_w = 32'(w4); obs_j = 32'(j4); obs_best = 32'(best4); obs_cnt = 32'(cnt4);
        obs_busy = busy4; obs_valid = valid4;
        for (int k = 0; k < 4; k++) obs_perm[4*k +: 4] = 4'(perm4[2*k +: 2]);
      end
      default: begin
        obs_w = 32'(w2); obs_j = 32'(j2); obs_best = 32'(best2); obs_cnt = 32'(cnt2);
        obs_busy = busy2; obs_valid = valid2;
        for (int k = 0; k < 2; k++) obs_perm[4*k +: 4] = 4'(perm2[k]);
      end
    endcase
  end

  // Reference model state: every permutation in lexicographic order.
  logic [31:0] exp_q[$];
  int          exp_best, exp_cnt;
  logic [31:0] exp_perm;

  function automatic int nsel(input int s);
    return (s == 0) ? 3 : (s == 1) ? 4 : 2;
  endfunction
  function automatic int cmax(input int s);
    return (s == 0) ? 127 : (s == 1) ? 7 : 15;
  endfunction
  function automatic int cntmax(input int s);
    return (s == 0) ? 65535 : (s == 1) ? 7 : 255;
  endfunction
  function automatic int fact(input int n);
    int f = 1;
    for (int i = 2; i <= n; i++) f *= i;
    return f;
  endfunction

  // Counting through all n-digit base-n tuples visits them in lexicographic
  // order; the ones with distinct digits are exactly the permutations.
  task automatic model(input int n, input int mode, input int cmx);
    int tmax, rem, sum;
    int d[8];
    bit ok;
    logic [31:0] word;
    exp_q.delete();
    exp_best = 0; exp_cnt = 0; exp_perm = '0;
    tmax = 1;
    for (int k = 0; k < n; k++) tmax *= n;
    for (int t = 0; t < tmax; t++) begin
      rem = t;
      for (int k = n - 1; k >= 0; k--) begin d[k] = rem % n; rem = rem / n; end
      ok = 1'b1;
      for (int a = 0; a < n; a++)
        for (int b = a + 1; b < n; b++)
          if (d[a] == d[b]) ok = 1'b0;
      if (ok) begin
        word = '0; sum = 0;
        for (int k = 0; k < n; k++) begin
          word = word | (32'(d[k]) << (4*k));
          sum += ct[k][d[k]];
        end
        if (exp_q.size() == 0 || (mode == 0 ? sum < exp_best : sum > exp_best)) begin
          exp_best = sum; exp_cnt = 1; exp_perm = word;
        end else if (sum == exp_best && exp_cnt < cmx) begin
          exp_cnt++;
        end
        exp_q.push_back(word);
      end
    end
  endtask

  task automatic fill_costs(input int hi);
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++)
        ct[w][j] = $urandom_range(0, hi);
  endtask

  // Drives one run on instance s and watches it until Valid. cyc counts cycles
  // from the first READ cycle; seq_err counts Busy drops and W/J deviations
  // from the model's permutation list. keep>=0 raises Start (Mode=keep) in the
  // DONE cycle; chain=1 means that held Start launches this run.
  task automatic do_run(input int s, input int mode, input bit flip, input bit chain,
                        input int keep, output int cyc, output int seq_err,
                        output logic v_after, output logic b_after);
    int n, p, q, idx, limit;
    sel = s;
    n = nsel(s);
    limit = fact(n) * (n + 2) + 20;
    if (!chain) begin
      @(negedge clk);
      start_v[s] = 1'b1;
      mode_v[s] = mode[0];
    end
    @(negedge clk);
    start_v[s] = 1'b0;
    cyc = 0;
    seq_err = 0;
    while (obs_valid !== 1'b1 && cyc < limit) begin
      p = cyc % (n + 2);
      idx = cyc / (n + 2);
      if (obs_busy !== 1'b1) seq_err++;
      if (p <= n && idx < exp_q.size()) begin
        q = (p < n) ? p : n - 1;
        if (obs_w !== 32'(q) || obs_j !== ((exp_q[idx] >> (4*q)) & 32'hf)) seq_err++;
      end
      if (flip && p == 1) begin
        start_v[s] = 1'b1;
        mode_v[s] = ~mode[0];
      end else begin
        start_v[s] = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    if (keep >= 0) begin
      start_v[s] = 1'b1;
      mode_v[s] = keep[0];
    end
    @(negedge clk);
    v_after = obs_valid;
    b_after = obs_busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_v = '0;
    mode_v = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      total++; if ({obs_busy, obs_valid, obs_w, obs_j, obs_best, obs_cnt, obs_perm} !== '0) begin bad++; $display("FAIL reset_outputs dut=%0d busy=%b valid=%b w=%0d j=%0d best=%0d cnt=%0d perm=%h want all zero", s, obs_busy, obs_valid, obs_w, obs_j, obs_best, obs_cnt, obs_perm); end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    sel = 0;
    #1;
    total++; if (obs_busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b want=0", obs_busy); end
  endtask

  task automatic test_uniform();
    int cyc, se;
    logic va, ba;
    for (int w = 0; w < 8; w++) for (int j = 0; j < 8; j++) ct[w][j] = 5;
    model(3, 0, cntmax(0));
    do_run(0, 0, 1'b0, 1'b0, -1, cyc, se, va, ba);
    total++; if (cyc !== 30) begin bad++; $display("FAIL uniform_latency got=%0d want=30", cyc); end
    total++; if (se !== 0) begin bad++; $display("FAIL uniform_sequence errors=%0d want=0", se); end
    total++; if (va !== 1'b0 || ba !== 1'b0) begin bad++; $display("FAIL uniform_pulse valid=%b busy=%b want 0 0", va, ba); end
    total++; if (obs_best !== 32'd15) begin bad++; $display("FAIL uniform_best got=%0d want=15", obs_best); end
    total++; if (obs_cnt !== 32'd6) begin bad++; $display("FAIL uniform_count got=%0d want=6", obs_cnt); end
    total++; if (obs_perm !== 32'h210) begin bad++; $display("FAIL uniform_perm got=%h want=210", obs_perm); end
  endtask

  task automatic test_saturate();
    int cyc, se;
    logic va, ba;
    for (int w = 0; w < 8; w++) for (int j = 0; j < 8; j++) ct[w][j] = 1;
    model(4, 0, cntmax(1));
    do_run(1, 0, 1'b0, 1'b0, -1, cyc, se, va, ba);
    total++; if (cyc !== 144) begin bad++; $display("FAIL sat_latency got=%0d want=144", cyc); end
    total++; if (se !== 0) begin bad++; $display("FAIL sat_sequence errors=%0d want=0", se); end
    total++; if (obs_cnt !== 32'd7) begin bad++; $display("FAIL sat_count got=%0d want=7", obs_cnt); end
    total++; if (obs_best !== 32'd4) begin bad++; $display("FAIL sat_best got=%0d want=4", obs_best); end
    total++; if (obs_perm !== 32'h3210) begin bad++; $display("FAIL sat_perm got=%h want=3210", obs_perm); end
  endtask

  task automatic test_distance();
    int cyc, se;
    logic va, ba;
    for (int w = 0; w < 8; w++) for (int j = 0; j < 8; j++) ct[w][j] = (w > j) ? w - j : j - w;
    for (int m = 0; m < 2; m++) begin
      model(4, m, cntmax(1));
      do_run(1, m, 1'b0, 1'b0, -1, cyc, se, va, ba);
      total++; if (se !== 0) begin bad++; $display("FAIL dist_sequence mode=%0d errors=%0d want=0", m, se); end
      total++; if (obs_best !== 32'(exp_best)) begin bad++; $display("FAIL dist_best mode=%0d got=%0d want=%0d", m, obs_best, exp_best); end
      total++; if (obs_cnt !== 32'(exp_cnt)) begin bad++; $display("FAIL dist_count mode=%0d got=%0d want=%0d", m, obs_cnt, exp_cnt); end
      total++; if (obs_perm !== exp_perm) begin bad++; $display("FAIL dist_perm mode=%0d got=%h want=%h", m, obs_perm, exp_perm); end
    end
  endtask

  task automatic test_n2();
    int cyc, se;
    logic va, ba;
    fill_costs(cmax(2));
    model(2, 1, cntmax(2));
    do_run(2, 1, 1'b0, 1'b0, -1, cyc, se, va, ba);
    total++; if (cyc !== 8) begin bad++; $display("FAIL n2_latency got=%0d want=8", cyc); end
    total++; if (se !== 0) begin bad++; $display("FAIL n2_sequence errors=%0d want=0", se); end
    total++; if (obs_best !== 32'(exp_best) || obs_cnt !== 32'(exp_cnt) || obs_perm !== exp_perm) begin bad++; $display("FAIL n2_result got=%0d/%0d/%h want=%0d/%0d/%h", obs_best, obs_cnt, obs_perm, exp_best, exp_cnt, exp_perm); end
  endtask

  task automatic test_random();
    int cyc, se, s, m;
    logic va, ba;
    for (int r = 0; r < 8; r++) begin
      s = $urandom_range(0, 2);
      m = $urandom_range(0, 1);
      fill_costs($urandom_range(0, 1) ? cmax(s) : 1);
      model(nsel(s), m, cntmax(s));
      do_run(s, m, 1'b0, 1'b0, -1, cyc, se, va, ba);
      total++; if (cyc !== fact(nsel(s)) * (nsel(s) + 2)) begin bad++; $display("FAIL rand_latency r=%0d dut=%0d got=%0d", r, s, cyc); end
      total++; if (se !== 0 || va !== 1'b0) begin bad++; $display("FAIL rand_sequence r=%0d dut=%0d errors=%0d valid_after=%b", r, s, se, va); end
      total++; if (obs_best !== 32'(exp_best) || obs_cnt !== 32'(exp_cnt) || obs_perm !== exp_perm) begin bad++; $display("FAIL rand_result r=%0d dut=%0d mode=%0d got=%0d/%0d/%h want=%0d/%0d/%h", r, s, m, obs_best, obs_cnt, obs_perm, exp_best, exp_cnt, exp_perm); end
    end
  endtask

  task automatic test_reset_midrun();
    int cyc, se;
    logic va, ba;
    sel = 0;
    fill_costs(cmax(0));
    model(3, 0, cntmax(0));
    @(negedge clk);
    start_v[0] = 1'b1;
    mode_v[0] = 1'b0;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (15) @(negedge clk);
    total++; if (obs_busy !== 1'b1 || obs_w !== 32'd0 || obs_j !== 32'd1) begin bad++; $display("FAIL midrun_position busy=%b w=%0d j=%0d want 1 0 1", obs_busy, obs_w, obs_j); end
    rst_n = 1'b0;
    @(negedge clk);
    total++; if ({obs_busy, obs_valid, obs_w, obs_j, obs_best, obs_cnt, obs_perm} !== '0) begin bad++; $display("FAIL midrun_reset busy=%b valid=%b w=%0d j=%0d best=%0d cnt=%0d perm=%h want all zero", obs_busy, obs_valid, obs_w, obs_j, obs_best, obs_cnt, obs_perm); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (obs_busy !== 1'b0 || obs_valid !== 1'b0) begin bad++; $display("FAIL midrun_idle busy=%b valid=%b want 0 0", obs_busy, obs_valid); end
    do_run(0, 0, 1'b0, 1'b0, -1, cyc, se, va, ba);
    total++; if (cyc !== 30 || se !== 0) begin bad++; $display("FAIL midrun_rerun latency=%0d errors=%0d want 30 0", cyc, se); end
    total++; if (obs_best !== 32'(exp_best) || obs_cnt !== 32'(exp_cnt) || obs_perm !== exp_perm) begin bad++; $display("FAIL midrun_result got=%0d/%0d/%h want=%0d/%0d/%h", obs_best, obs_cnt, obs_perm, exp_best, exp_cnt, exp_perm); end
  endtask

  task automatic test_busy_start();
    int cyc, se;
    logic va, ba;
    fill_costs(cmax(0));
    model(3, 0, cntmax(0));
    do_run(0, 0, 1'b1, 1'b0, -1, cyc, se, va, ba);
    total++; if (cyc !== 30 || se !== 0) begin bad++; $display("FAIL busy_start_seq latency=%0d errors=%0d want 30 0", cyc, se); end
    total++; if (va !== 1'b0 || ba !== 1'b0) begin bad++; $display("FAIL busy_start_pulse valid=%b busy=%b want 0 0", va, ba); end
    total++; if (obs_best !== 32'(exp_best) || obs_cnt !== 32'(exp_cnt) || obs_perm !== exp_perm) begin bad++; $display("FAIL busy_start_result got=%0d/%0d/%h want=%0d/%0d/%h", obs_best, obs_cnt, obs_perm, exp_best, exp_cnt, exp_perm); end
  endtask

  task automatic test_back_to_back();
    int cyc, se;
    logic va, ba;
    fill_costs(cmax(0));
    model(3, 1, cntmax(0));
    do_run(0, 1, 1'b0, 1'b0, 0, cyc, se, va, ba);
    total++; if (ba !== 1'b0 || va !== 1'b0) begin bad++; $display("FAIL b2b_done_start busy=%b valid=%b want 0 0", ba, va); end
    total++; if (obs_best !== 32'(exp_best) || obs_cnt !== 32'(exp_cnt) || obs_perm !== exp_perm) begin bad++; $display("FAIL b2b_first got=%0d/%0d/%h want=%0d/%0d/%h", obs_best, obs_cnt, obs_perm, exp_best, exp_cnt, exp_perm); end
    model(3, 0, cntmax(0));
    do_run(0, 0, 1'b0, 1'b1, -1, cyc, se, va, ba);
    total++; if (cyc !== 30 || se !== 0) begin bad++; $display("FAIL b2b_second_seq latency=%0d errors=%0d want 30 0", cyc, se); end
    total++; if (obs_best !== 32'(exp_best) || obs_cnt !== 32'(exp_cnt) || obs_perm !== exp_perm) begin bad++; $display("FAIL b2b_second got=%0d/%0d/%h want=%0d/%0d/%h", obs_best, obs_cnt, obs_perm, exp_best, exp_cnt, exp_perm); end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_saturate();
    test_distance();
    test_n2();
    test_random();
    test_reset_midrun();
    test_busy_start();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
